// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store engine.
// Holds the width and extension codes, the FSM state encoding, lane geometry
// and the alignment rule that decides whether a request is rejected.
package mem_access_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;
   localparam logic [1:0] WIDTH_BAD  = 2'b11;

   localparam logic SIGN_EXT = 1'b0;
   localparam logic ZERO_EXT = 1'b1;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAPT = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_e;

   // True when the access cannot be performed: invalid width code, odd half
   // address, or a word address that is not 4-byte aligned.
   function automatic logic is_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
      logic bad;
      case (width)
         WIDTH_BYTE: bad = 1'b0;
         WIDTH_HALF: bad = addr_lo[0];
         WIDTH_WORD: bad = |addr_lo;
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the load/store engine.
// Ports:
//   word        : word read from data memory
//   addr_lo     : byte offset within the word
//   width       : access width code
//   sign_flag   : 0 sign-extend, 1 zero-extend (sub-word loads)
//   store_data  : store data, low bits used for sub-word stores
//   load_data   : selected lane, extended to 32 bits
//   merged      : old word with the addressed lane(s) replaced by store_data
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  width,
   input  logic        sign_flag,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [LANE_W-1:0] byte_sel;
   logic [15:0]       half_sel;
   logic [4:0]        byte_lsb;

   assign byte_lsb = {addr_lo, 3'b000};
   assign byte_sel = word[byte_lsb +: LANE_W];
   assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

   always_comb begin
      load_data = word;
      merged    = word;
      case (width)
         WIDTH_BYTE: begin
            load_data = (sign_flag == ZERO_EXT) ? {24'h0, byte_sel}
                                                : {{24{byte_sel[7]}}, byte_sel};
            merged[byte_lsb +: LANE_W] = store_data[7:0];
         end
         WIDTH_HALF: begin
            load_data = (sign_flag == ZERO_EXT) ? {16'h0, half_sel}
                                                : {{16{half_sel[15]}}, half_sel};
            if (addr_lo[1]) merged[31:16] = store_data[15:0];
            else            merged[15:0]  = store_data[15:0];
         end
         default: begin
            load_data = word;
            merged    = store_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine against a word-wide synchronous-read memory.
// Sub-word stores are done as read-modify-write.
//
//   state | meaning
//   IDLE  | ready for a request (o_ready=1)
//   RD    | word address driven, memory read in flight
//   CAPT  | read word available: register load result or merged store word
//   WR    | one-cycle memory write
//   DONE  | completion pulse, o_misaligned valid
//
// Ports:
//   clk, i_reset (async, active-low)
//   i_valid/o_ready handshake, i_memRead, i_memWrite, i_width, i_sign_flag,
//   i_addr (byte address), i_wdata
//   o_rdata (last load result), o_done, o_misaligned
//   o_mem_addr, o_mem_we, o_mem_wdata, i_mem_rdata (memory side)
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int NB_DATA    = 32,
   parameter int NB_ADDR    = 32,
   parameter int MEM_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_memRead,
   input  logic                  i_memWrite,
   input  logic [1:0]            i_width,
   input  logic                  i_sign_flag,
   input  logic [NB_ADDR-1:0]    i_addr,
   input  logic [NB_DATA-1:0]    i_wdata,
   output logic [NB_DATA-1:0]    o_rdata,
   output logic                  o_done,
   output logic                  o_misaligned,
   output logic [MEM_ADDR_W-1:0] o_mem_addr,
   output logic                  o_mem_we,
   output logic [NB_DATA-1:0]    o_mem_wdata,
   input  logic [NB_DATA-1:0]    i_mem_rdata
);

   state_e state_q, state_d;

   logic [MEM_ADDR_W+1:0] addr_q;
   logic [1:0]            width_q;
   logic                  sign_q;
   logic                  is_load_q;
   logic                  err_q;
   logic [NB_DATA-1:0]    wdata_q;
   logic [NB_DATA-1:0]    rdata_q;

   logic                  accept;
   logic                  req_bad;
   logic [NB_DATA-1:0]    load_data;
   logic [NB_DATA-1:0]    merged;

   // Address bits above the memory range wrap silently.
   logic unused_addr_hi;
   assign unused_addr_hi = ^i_addr[NB_ADDR-1:MEM_ADDR_W+2];

   assign accept  = (state_q == S_IDLE) && i_valid && (i_memRead || i_memWrite);
   assign req_bad = is_misaligned(i_width, i_addr[1:0]);

   mem_lane_align u_align (
      .word       (i_mem_rdata),
      .addr_lo    (addr_q[1:0]),
      .width      (width_q),
      .sign_flag  (sign_q),
      .store_data (wdata_q),
      .load_data  (load_data),
      .merged     (merged)
   );

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         width_q   <= WIDTH_BYTE;
         sign_q    <= SIGN_EXT;
         is_load_q <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q    <= i_addr[MEM_ADDR_W+1:0];
            width_q   <= i_width;
            sign_q    <= i_sign_flag;
            is_load_q <= i_memRead;   // read wins when both are set
            err_q     <= req_bad;
            wdata_q   <= i_wdata;
         end
         // wdata_q doubles as the memory write word: full store data for a
         // word store, replaced by the merged word for a sub-word store.
         if (state_q == S_CAPT) begin
            if (is_load_q) rdata_q <= load_data;
            else           wdata_q <= merged;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      o_ready      = 1'b0;
      o_done       = 1'b0;
      o_misaligned = 1'b0;
      o_mem_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_ready = 1'b1;
            if (accept) begin
               if (req_bad)                  state_d = S_DONE;
               else if (i_memRead)           state_d = S_RD;
               else if (i_width == WIDTH_WORD) state_d = S_WR;
               else                          state_d = S_RD;
            end
         end
         S_RD:   state_d = S_CAPT;
         S_CAPT: state_d = is_load_q ? S_DONE : S_WR;
         S_WR: begin
            o_mem_we = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            o_done       = 1'b1;
            o_misaligned = err_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_mem_addr  = addr_q[MEM_ADDR_W+1:2];
   assign o_mem_wdata = wdata_q;
   assign o_rdata     = rdata_q;

endmodule
